mul_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit sitting beside the ALU in the execute stage. Consumes the same two operands the operand-prep block drives into the ALU (readData1/readData2) and produces a 32-bit result for the writeback/data-cache path. It covers MUL, SDIV and UDIV, which the single-cycle ALU does not. A start/busy/done handshake lets the controller stall the PC while the unit iterates.

---
 rtl/arm_lp_pkg.sv | 25 ++
 rtl/mul_div_unit.sv | 132 +++++++++++++
 tb/tb_mul_div_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/arm_lp_pkg.sv
// Shared encodings for the execute stage: op codes, multiply/divide FSM states
// and the datapath width used by the ALU, controller and mul_div_unit.
package arm_lp_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    MUL_OP  = 2'd0,
    SDIV_OP = 2'd1,
    UDIV_OP = 2'd2,
    RSVD_OP = 2'd3
  } opCode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is correct unsigned.
  function automatic logic [DATA_WIDTH-1:0] absVal(input logic [DATA_WIDTH-1:0] value);
    absVal = value[DATA_WIDTH-1] ? (~value + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : value;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MUL / SDIV / UDIV unit: one multiplier or quotient bit per
// cycle through a shared 64-bit shift register, with a start/busy/done handshake.
module mul_div_unit
  import arm_lp_pkg::*;
(
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [1:0]            opCode,
  input  logic [DATA_WIDTH-1:0] operandA,
  input  logic [DATA_WIDTH-1:0] operandB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zeroFlag
);

  state_e                  state_r, stateNext_s;
  opCode_e                 op_r, opIn_s;
  logic [4:0]              cnt_r;
  logic [2*DATA_WIDTH-1:0] acc_r, stepAcc_s;
  logic [DATA_WIDTH-1:0]   opB_r, quot_s, finalRes_s;
  logic                    neg_r, busy_r, done_r, zero_r;
  logic [DATA_WIDTH-1:0]   result_r;
  logic [DATA_WIDTH:0]     mulSum_s, remTry_s, remDiff_s;
  logic                    accept_s, shortCut_s, lastStep_s;

  assign opIn_s = opCode_e'(opCode);

  // One shift-add (MUL) or restoring-divide step on the shared accumulator.
  always_comb begin
    mulSum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opB_r} : 33'd0);
    remTry_s  = acc_r[63:31];
    remDiff_s = remTry_s - {1'b0, opB_r};
    if (op_r == MUL_OP) begin
      stepAcc_s = {mulSum_s, acc_r[31:1]};
    end else if (!remDiff_s[32]) begin
      stepAcc_s = {remDiff_s[31:0], acc_r[30:0], 1'b1};
    end else begin
      stepAcc_s = {acc_r[62:0], 1'b0};
    end
    quot_s = stepAcc_s[31:0];
    if (op_r == MUL_OP) begin
      finalRes_s = stepAcc_s[31:0];
    end else if (neg_r) begin
      finalRes_s = ~quot_s + 32'd1;
    end else begin
      finalRes_s = quot_s;
    end
  end

  // Next-state logic; reserved ops and divide-by-zero skip RUN entirely.
  always_comb begin
    stateNext_s = state_r;
    accept_s    = start && (state_r != RUN);
    shortCut_s  = (opIn_s == RSVD_OP) ||
                  (((opIn_s == SDIV_OP) || (opIn_s == UDIV_OP)) && (operandB == 32'd0));
    lastStep_s  = (state_r == RUN) && (cnt_r == 5'd0);
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          stateNext_s = shortCut_s ? DONE : RUN;
        end else begin
          stateNext_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == 5'd0) begin
          stateNext_s = DONE;
        end else begin
          stateNext_s = RUN;
        end
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake/result outputs.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_r  <= IDLE;
      op_r     <= MUL_OP;
      cnt_r    <= 5'd0;
      acc_r    <= 64'd0;
      opB_r    <= 32'd0;
      neg_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 32'd0;
      zero_r   <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      busy_r  <= (stateNext_s == RUN);
      done_r  <= (stateNext_s == DONE);
      if (accept_s && shortCut_s) begin
        result_r <= 32'd0;
        zero_r   <= 1'b1;
      end else if (accept_s) begin
        op_r  <= opIn_s;
        cnt_r <= 5'd31;
        neg_r <= (opIn_s == SDIV_OP) && (operandA[31] ^ operandB[31]);
        if (opIn_s == MUL_OP) begin
          acc_r <= {32'd0, operandB};
          opB_r <= operandA;
        end else if (opIn_s == SDIV_OP) begin
          acc_r <= {32'd0, absVal(operandA)};
          opB_r <= absVal(operandB);
        end else begin
          acc_r <= {32'd0, operandA};
          opB_r <= operandB;
        end
      end else if (state_r == RUN) begin
        acc_r <= stepAcc_s;
        cnt_r <= cnt_r - 5'd1;
        if (lastStep_s) begin
          result_r <= finalRes_s;
          zero_r   <= (finalRes_s == 32'd0);
        end else begin
          result_r <= result_r;
        end
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;
  assign zeroFlag = zero_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: latency, arithmetic corner
// cases, short-circuit ops, back-to-back handshake, mid-op reset and operand churn.
module tb_mul_div_unit;
  import arm_lp_pkg::*;

  logic        clock = 1'b0;
  logic        resetN;
  logic        start;
  logic [1:0]  opCode;
  logic [31:0] operandA, operandB;
  logic        busy, done, zeroFlag;
  logic [31:0] result;

  int vecCount  = 0;
  int missCount = 0;
  int cyc, busyCnt;
  bit sawDone;

  mul_div_unit dut (
    .clock    (clock),
    .resetN   (resetN),
    .start    (start),
    .opCode   (opCode),
    .operandA (operandA),
    .operandB (operandB),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zeroFlag (zeroFlag)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    opCode   = op;
    operandA = a;
    operandB = b;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the accepting edge; counts edges until done and busy samples before it.
  task automatic waitDone(input bit churn, input bit glitch, output int edges, output int busyN);
    edges = 0;
    busyN = 0;
    while (!done && edges < 40) begin
      if (busy) busyN++;
      if (churn) begin
        operandA = $urandom;
        operandB = $urandom;
      end
      if (glitch) begin
        start  = (edges == 5);
        opCode = RSVD_OP;
      end
      @(posedge clock);
      #1;
      edges++;
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes, input bit expZero,
                       input bit normal, input bit churn, input bit glitch);
    int edges, busyN;
    logic [31:0] held;
    startOp(op, a, b);
    waitDone(churn, glitch, edges, busyN);
    start = 1'b0;
    check({tag, ".result"}, result, expRes);
    check({tag, ".zero"}, {31'd0, zeroFlag}, {31'd0, expZero});
    check({tag, ".latency"}, edges, normal ? 32'd32 : 32'd0);
    check({tag, ".busyCycles"}, busyN, normal ? 32'd32 : 32'd0);
    held = result;
    @(posedge clock);
    #1;
    check({tag, ".donePulse"}, {31'd0, done}, 32'd0);
    check({tag, ".held"}, result, held);
  endtask

  initial begin
    resetN   = 1'b0;
    start    = 1'b0;
    opCode   = MUL_OP;
    operandA = 32'd0;
    operandB = 32'd0;
    #12;
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.result", result, 32'd0);
    check("reset.zero", {31'd0, zeroFlag}, 32'd0);
    @(negedge clock);
    resetN = 1'b1;

    runOp("mul15x15", MUL_OP, 32'd15, 32'd15, 32'd225, 1'b0, 1'b1, 1'b0, 1'b0);
    runOp("udivMax10", UDIV_OP, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 1'b0, 1'b1, 1'b0, 1'b0);
    runOp("sdivM7by2", SDIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0, 1'b0);
    runOp("sdivMinByM1", SDIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    runOp("mulWrapZero", MUL_OP, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    runOp("mulSigned", MUL_OP, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 1'b1, 1'b0, 1'b0);
    runOp("udivBy0", UDIV_OP, 32'd10, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    runOp("mul6x7", MUL_OP, 32'd6, 32'd7, 32'd42, 1'b0, 1'b1, 1'b0, 1'b0);
    runOp("rsvdOp", RSVD_OP, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start held high across both ops.
    @(negedge clock);
    opCode   = MUL_OP;
    operandA = 32'd3;
    operandB = 32'd4;
    start    = 1'b1;
    @(posedge clock);
    #1;
    opCode   = UDIV_OP;
    operandA = 32'd100;
    operandB = 32'd7;
    waitDone(1'b0, 1'b0, cyc, busyCnt);
    check("b2b.mul.result", result, 32'd12);
    check("b2b.mul.latency", cyc, 32'd32);
    check("b2b.mul.busyCycles", busyCnt, 32'd32);
    @(posedge clock);
    #1;
    start = 1'b0;
    check("b2b.gap.done", {31'd0, done}, 32'd0);
    check("b2b.gap.busy", {31'd0, busy}, 32'd1);
    waitDone(1'b0, 1'b0, cyc, busyCnt);
    check("b2b.udiv.result", result, 32'd14);
    check("b2b.udiv.latency", cyc, 32'd32);

    runOp("churnUdiv", UDIV_OP, 32'd1000, 32'd8, 32'd125, 1'b0, 1'b1, 1'b1, 1'b1);

    // Reset dropped mid-MUL: outputs clear asynchronously and no done follows.
    startOp(MUL_OP, 32'h1234_5678, 32'h9);
    repeat (9) @(posedge clock);
    #3;
    resetN = 1'b0;
    #1;
    check("midReset.busy", {31'd0, busy}, 32'd0);
    check("midReset.done", {31'd0, done}, 32'd0);
    check("midReset.result", result, 32'd0);
    check("midReset.zero", {31'd0, zeroFlag}, 32'd0);
    repeat (3) @(negedge clock);
    resetN  = 1'b1;
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done || busy) sawDone = 1'b1;
    end
    check("midReset.noDone", {31'd0, sawDone}, 32'd0);
    runOp("sdiv100byM10", SDIV_OP, 32'd100, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
